// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared definitions for the core's program-counter generator.
//   - pc_state_e           : FSM state encoding (PC_BOOT=0, PC_RUN=1, PC_HALT=2;
//                            encoding 3 is unused and recovers to PC_BOOT)
//   - PC_RESET_VEC_DEFAULT : default first fetch address after reset
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    PC_BOOT = 2'd0,
    PC_RUN  = 2'd1,
    PC_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//   Program-counter generator. Presents the fetch address to instruction memory
//   through a valid/ready handshake, loads RESET_VEC after boot and then steps
//   by INC_STEP on every accepted fetch. Supports trap and branch/jump
//   redirects, stall, and halt/resume.
//
// Parameters
//   AW        : address width in bits
//   INC_STEP  : sequential increment, a power of two
//   RESET_VEC : first fetch address after reset
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   stall         in   hold the current address
//   redirect_en   in   branch/jump taken
//   redirect_addr in   branch/jump target
//   trap_en       in   trap/exception entry (highest priority)
//   trap_vec      in   trap handler address
//   halt_req      in   request HALT
//   resume        in   leave HALT
//   fetch_ready   in   instruction memory accepts addr
//   addr          out  current fetch address
//   addr_valid    out  addr is a live fetch request (RUN only)
//   misalign_err  out  one-cycle pulse on a rejected misaligned redirect
//                      (present only with PC_GEN_MISALIGN_CHK_EN)
//   state_o       out  FSM state (BOOT=0, RUN=1, HALT=2)
//
// Configuration
//   PC_GEN_MISALIGN_CHK_EN : when defined, a redirect target that is not a
//   multiple of INC_STEP is not taken; the PC goes to trap_vec instead and
//   misalign_err pulses. When undefined every redirect is taken unchecked.
// -----------------------------------------------------------------------------
module pc_gen
  import core_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            INC_STEP  = 1,
  parameter logic [AW-1:0] RESET_VEC = AW'(PC_RESET_VEC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          redirect_en,
  input  logic [AW-1:0] redirect_addr,
  input  logic          trap_en,
  input  logic [AW-1:0] trap_vec,
  input  logic          halt_req,
  input  logic          resume,
  input  logic          fetch_ready,
  output logic [AW-1:0] addr,
  output logic          addr_valid,
`ifdef PC_GEN_MISALIGN_CHK_EN
  output logic          misalign_err,
`endif
  output logic [1:0]    state_o
);

  localparam logic [AW-1:0] STEP = AW'(INC_STEP);

  pc_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          misalign_hit;

`ifdef PC_GEN_MISALIGN_CHK_EN
  // Low address bits below the step size must be zero; for INC_STEP=1 the
  // mask is zero and the check can never fire.
  localparam logic [AW-1:0] ALIGN_MASK = AW'(INC_STEP - 1);

  logic misalign_q, misalign_d;

  assign misalign_hit = redirect_en && ((redirect_addr & ALIGN_MASK) != '0);
  // The error only reports a redirect that was actually rejected, i.e. one
  // not already overridden by a trap and seen in a state that honours it.
  assign misalign_d   = misalign_hit && !trap_en &&
                        ((state_q == PC_RUN) || (state_q == PC_HALT));
`else
  assign misalign_hit = 1'b0;
`endif

  // ---- next-state / next-address ----
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      PC_BOOT: begin
        state_d = PC_RUN;
      end
      PC_RUN: begin
        // A rejected (misaligned) redirect behaves like a trap.
        if (trap_en || misalign_hit) begin
          addr_d = trap_vec;
        end else if (redirect_en) begin
          addr_d = redirect_addr;
        end else if (halt_req) begin
          state_d = PC_HALT;
        end else if (!stall && fetch_ready) begin
          addr_d = addr_q + STEP;
        end
      end
      PC_HALT: begin
        if (trap_en || misalign_hit) begin
          addr_d  = trap_vec;
          state_d = PC_RUN;
        end else if (redirect_en) begin
          addr_d = redirect_addr;
        end else if (resume && !halt_req) begin
          state_d = PC_RUN;
        end
      end
      default: begin
        state_d = PC_BOOT;
      end
    endcase
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PC_BOOT;
      addr_q  <= RESET_VEC;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef PC_GEN_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`endif

  // ---- outputs ----
  assign addr       = addr_q;
  assign addr_valid = (state_q == PC_RUN);
  assign state_o    = state_q;

endmodule
